router_pkt_tx: RTL and testbench
================================

# router_pkt_tx

Packet transmitter that drives the input port of the 1x3 router (`pkt_valid`, `data_in`, `busy`, `err`). It accepts a command (destination address, payload length) and a payload byte stream from a host. It stores the whole payload, then emits header, payload and parity bytes under the router's `busy` flow control, and reports completion with the router's parity-error verdict. It sits between the test/host logic and the router top.

## Interface
- `CHK_WAIT`, default 2: cycles spent in CHECK after the parity byte is accepted; `err` is sampled on the last one.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_addr` in 2: destination port, legal values 0..2.
- `cmd_len` in 6: payload byte count, legal values 1..63.
- `pl_valid` in 1: payload byte valid.
- `pl_ready` out 1: payload byte taken when `pl_valid && pl_ready`.
- `pl_data` in 8: payload byte.
- `pkt_valid` out 1: to the router; high during header and payload, low during parity.
- `data_in` out 8: byte to the router.
- `busy` in 1: router busy; the driven byte is held while it is 1.
- `err` in 1: router parity-error flag.
- `tx_done` out 1: one-cycle pulse when the packet completes.
- `tx_err` out 1: `err` captured with `tx_done`; holds its value until the next `tx_done`.
- `bad_cmd` out 1: one-cycle pulse when an illegal command is dropped.

## Operation
- States: IDLE, FILL, HEADER, PAYLOAD, PARITY, CHECK.
- **IDLE**
  - `cmd_ready`=1.
  - On handshake with `cmd_addr`==3 or `cmd_len`==0: pulse `bad_cmd` next cycle, stay in IDLE, send nothing.
  - Otherwise latch addr and len, clear the byte counter and the parity register, go to FILL.
- **FILL**
  - `pl_ready`=1 while count < len.
  - Each handshake writes `pl_data` to buffer[count] and increments count.
  - On the handshake that makes count==len: go to HEADER and clear count.
  - `pl_valid` gaps are allowed and only stretch FILL.
- **HEADER**
  - Drive `pkt_valid`=1 and `data_in`={len[5:0],addr[1:0]}.
  - At a rising edge with `busy`==0: parity ^= header, go to PAYLOAD.
- **PAYLOAD**
  - Drive `pkt_valid`=1 and `data_in`=buffer[count].
  - At an edge with `busy`==0: parity ^= byte, count++.
  - After byte len-1 is accepted: go to PARITY.
  - No bubbles are ever inserted: store-and-forward guarantees this.
- **PARITY**
  - Drive `pkt_valid`=0 and `data_in`=parity.
  - At an edge with `busy`==0: go to CHECK and load the wait counter with CHK_WAIT.
- **CHECK**
  - Drive `pkt_valid`=0 and `data_in`=0.
  - Decrement the counter each cycle.
  - At 1: capture `err` into `tx_err`, pulse `tx_done`, go to IDLE.
- Parity is the bytewise XOR over the header and all payload bytes, 8 bits, no carry.
- Counter is 6 bits; it never wraps because len ≤ 63.
- Buffer is 64x8; entry 63 is unused.

## Timing
- Reset values:
  - state IDLE.
  - `cmd_ready`=1.
  - `pl_ready`=0.
  - `pkt_valid`=0.
  - `data_in`=0.
  - `tx_done`=0.
  - `tx_err`=0.
  - `bad_cmd`=0.
  - Counters 0 and parity 0; buffer contents are don't-care.
- All outputs are registered-state decodes; none depends combinationally on `busy`.
- Command handshake to FILL: 1 cycle.
- Last payload handshake to header on `data_in`: 1 cycle.
- With `busy` held at 0, the packet occupies exactly len+2 consecutive cycles on `data_in`: header, then len payload bytes, then parity.
- `busy`==1 at an edge: state, `data_in` and `pkt_valid` are unchanged. Hold is unbounded, with no timeout.
- `cmd_valid` and `pl_valid` are ignored outside IDLE and FILL respectively.
- `reset` asserted mid-packet: next cycle is IDLE with `pkt_valid`=0. The partial packet is abandoned, and the router is recovered by its own reset or soft reset.
- `err` is sampled only in the final CHECK cycle.

## Structure
- Shared package `router_pkg` holds:
  - the state enum;
  - `ADDR_W`=2, `LEN_W`=6, `MAX_LEN`=63;
  - header field positions: len at [7:2], addr at [1:0];
  - `NUM_PORTS`=3.
- One sub-module, `router_tx_buf`: a 64x8 register array with one synchronous write port and one combinational read port.
- FSM, counters and parity live in `router_pkt_tx`.

## Test plan
- **Single packet, no stall.** Command addr=1, len=3; payload 0x11, 0x22, 0x33; `busy`=0.
  - `data_in` = 0x0D, 0x11, 0x22, 0x33, 0x0D, with `pkt_valid` 1,1,1,1,0.
  - `tx_done` fires CHK_WAIT cycles after the parity byte.
- **Router busy.** addr=2, len=2; `busy`=1 for 3 cycles right after the header is accepted, then 1 cycle mid-payload.
  - Each byte holds steady during the stall, and no byte is skipped or repeated.
- **Illegal commands.** addr=3 with len=4, then addr=0 with len=0.
  - `bad_cmd` pulses twice.
  - `pkt_valid` stays 0 and `pl_ready` stays 0.
- **Maximum length with FILL gaps.** len=63 with `pl_valid` toggled every other cycle.
  - 63 payload bytes are emitted in order.
  - Header = 0xFC | addr.
  - Parity matches the reference XOR.
- **Error report.** `err`=1 in the final CHECK cycle.
  - `tx_err`=1 with `tx_done`, and it stays 1 until the next packet's `tx_done`.
- **Reset mid-payload.** `reset` asserted for 1 cycle during byte 5 of a len=10 packet.
  - Next cycle: `pkt_valid`=0, `cmd_ready`=1.
  - A new command then completes normally.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter.
package router_pkg;
  localparam int ADDR_W       = 2;
  localparam int LEN_W        = 6;
  localparam int MAX_LEN      = 63;
  localparam int NUM_PORTS    = 3;
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_HEADER, S_PAYLOAD, S_PARITY, S_CHECK
  } tx_state_e;

  function automatic logic [7:0] mk_header(input logic [LEN_W-1:0] len,
                                           input logic [ADDR_W-1:0] addr);
    logic [7:0] h;
    h = '0;
    h[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
    h[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
    return h;
  endfunction
endpackage

// File: rtl/router_tx_buf.sv
// Payload store: register array, one synchronous write port, one combinational read port.
module router_tx_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 8
) (
  input  logic          clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/router_pkt_tx.sv
// Store-and-forward packet source for the router input port: buffers the payload,
// then sends header/payload/parity under busy and reports the router's err verdict.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int CHK_WAIT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic [7:0]        pl_data,
  output logic              pkt_valid,
  output logic [7:0]        data_in,
  input  logic              busy,
  input  logic              err,
  output logic              tx_done,
  output logic              tx_err,
  output logic              bad_cmd
);
  tx_state_e         r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic [7:0]        r_par;
  logic [7:0]        r_wait;
  logic              r_tx_done, r_tx_err, r_bad_cmd;

  logic              w_pl_fire;
  logic              w_last;
  logic [7:0]        w_hdr;
  logic [7:0]        w_rdata;

  assign w_pl_fire = pl_valid && pl_ready;
  assign w_last    = (r_cnt == r_len - LEN_W'(1));
  assign w_hdr     = mk_header(r_len, r_addr);

  router_tx_buf #(.DEPTH(MAX_LEN + 1), .AW(LEN_W), .DW(8)) u_buf (
    .clock   (clock),
    .i_we    (w_pl_fire),
    .i_waddr (r_cnt),
    .i_wdata (pl_data),
    .i_raddr (r_cnt),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_par     <= '0;
      r_wait    <= '0;
      r_tx_done <= 1'b0;
      r_tx_err  <= 1'b0;
      r_bad_cmd <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      r_bad_cmd <= 1'b0;
      case (r_state)
        S_IDLE: if (cmd_valid) begin
          if (cmd_addr >= ADDR_W'(NUM_PORTS) || cmd_len == '0) begin
            r_bad_cmd <= 1'b1;
          end else begin
            r_addr  <= cmd_addr;
            r_len   <= cmd_len;
            r_cnt   <= '0;
            r_par   <= '0;
            r_state <= S_FILL;
          end
        end
        S_FILL: if (w_pl_fire) begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= S_HEADER;
          end else begin
            r_cnt <= r_cnt + LEN_W'(1);
          end
        end
        S_HEADER: if (!busy) begin
          r_par   <= r_par ^ w_hdr;
          r_state <= S_PAYLOAD;
        end
        S_PAYLOAD: if (!busy) begin
          r_par <= r_par ^ w_rdata;
          r_cnt <= r_cnt + LEN_W'(1);
          if (w_last) r_state <= S_PARITY;
        end
        S_PARITY: if (!busy) begin
          r_wait  <= 8'(CHK_WAIT);
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          r_wait <= r_wait - 8'd1;
          // <= keeps a zero wait from wrapping into a 255-cycle stall
          if (r_wait <= 8'd1) begin
            r_tx_err  <= err;
            r_tx_done <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    data_in = 8'h00;
    case (r_state)
      S_HEADER:  data_in = w_hdr;
      S_PAYLOAD: data_in = w_rdata;
      S_PARITY:  data_in = r_par;
      default:   data_in = 8'h00;
    endcase
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign pl_ready  = (r_state == S_FILL) && (r_cnt < r_len);
  assign pkt_valid = (r_state == S_HEADER) || (r_state == S_PAYLOAD);
  assign tx_done   = r_tx_done;
  assign tx_err    = r_tx_err;
  assign bad_cmd   = r_bad_cmd;
endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: byte stream, busy holds, illegal commands, err report, reset.
module tb_router_pkt_tx;
  localparam int CHK_WAIT = 2;

  logic       clock, reset;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_addr;
  logic [5:0] cmd_len;
  logic       pl_valid, pl_ready;
  logic [7:0] pl_data;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       busy, err;
  logic       tx_done, tx_err, bad_cmd;

  int total = 0;
  int bad   = 0;
  logic [7:0] pay [64];

  router_pkt_tx #(.CHK_WAIT(CHK_WAIT)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
    .pkt_valid(pkt_valid), .data_in(data_in), .busy(busy), .err(err),
    .tx_done(tx_done), .tx_err(tx_err), .bad_cmd(bad_cmd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] a, input logic [5:0] l);
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic fill(input int len, input bit gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps) begin
        pl_valid = 1'b0;
        tick();
      end
      pl_valid = 1'b1;
      pl_data  = pay[i];
      total++;
      if (pl_ready !== 1'b1) begin
        bad++; $display("FAIL pl_ready_fill: byte %0d got %b want 1", i, pl_ready);
      end
      tick();
    end
    pl_valid = 1'b0;
  endtask

  // Sends one packet: command, fill, stream (with optional busy stalls and
  // junk on the ignored inputs), then checks done latency and err capture.
  task automatic run_pkt(input string nm, input logic [1:0] a, input logic [5:0] l,
                         input logic [127:0] stall, input bit gaps, input bit noise,
                         input logic err_flag, input logic prev_err);
    logic [7:0] exp_b[$];
    logic       exp_v[$];
    logic [7:0] got_b[$];
    logic       got_v[$];
    logic [7:0] par, pb;
    logic       pv, pbusy;
    int cyc, n;
    par = {l, a};
    exp_b.push_back({l, a}); exp_v.push_back(1'b1);
    for (int i = 0; i < int'(l); i++) begin
      exp_b.push_back(pay[i]); exp_v.push_back(1'b1);
      par ^= pay[i];
    end
    exp_b.push_back(par); exp_v.push_back(1'b0);

    send_cmd(a, l);
    fill(int'(l), gaps);
    total++;
    if (tx_err !== prev_err) begin
      bad++; $display("FAIL %s tx_err_hold: got %b want %b", nm, tx_err, prev_err);
    end
    if (noise) begin
      cmd_valid = 1'b1; cmd_addr = 2'd3; cmd_len = 6'd0;
      pl_valid = 1'b1; pl_data = 8'hEE;
    end
    cyc = 0; pbusy = 1'b0; pb = 8'h00; pv = 1'b0;
    while (got_b.size() < int'(l) + 2 && cyc < 1000) begin
      busy = (cyc < 128) ? stall[cyc] : 1'b0;
      if (pbusy) begin
        total++;
        if (data_in !== pb || pkt_valid !== pv) begin
          bad++; $display("FAIL %s hold: cyc %0d got %h/%b want %h/%b", nm, cyc, data_in, pkt_valid, pb, pv);
        end
      end
      total++;
      if (cmd_ready !== 1'b0 || pl_ready !== 1'b0) begin
        bad++; $display("FAIL %s ready_in_stream: cyc %0d got %b/%b want 0/0", nm, cyc, cmd_ready, pl_ready);
      end
      if (!busy) begin
        got_b.push_back(data_in); got_v.push_back(pkt_valid);
      end
      pb = data_in; pv = pkt_valid; pbusy = busy;
      tick();
      cyc++;
    end
    busy = 1'b0; cmd_valid = 1'b0; pl_valid = 1'b0;
    total++;
    if (got_b.size() != int'(l) + 2) begin
      bad++; $display("FAIL %s stream_len: got %0d want %0d", nm, got_b.size(), int'(l) + 2);
    end else begin
      for (int i = 0; i < int'(l) + 2; i++) begin
        total++;
        if (got_b[i] !== exp_b[i] || got_v[i] !== exp_v[i]) begin
          bad++; $display("FAIL %s byte%0d: got %h/%b want %h/%b", nm, i, got_b[i], got_v[i], exp_b[i], exp_v[i]);
        end
      end
    end
    n = 0;
    while (tx_done !== 1'b1 && n < 20) begin
      err = (n == CHK_WAIT - 1) ? err_flag : ~err_flag;
      tick();
      n++;
    end
    err = 1'b0;
    total++;
    if (n != CHK_WAIT) begin
      bad++; $display("FAIL %s done_latency: got %0d want %0d", nm, n, CHK_WAIT);
    end
    total++;
    if (tx_done !== 1'b1 || tx_err !== err_flag || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL %s done: got done=%b err=%b rdy=%b want 1/%b/1", nm, tx_done, tx_err, cmd_ready, err_flag);
    end
    tick();
    total++;
    if (tx_done !== 1'b0 || tx_err !== err_flag || bad_cmd !== 1'b0) begin
      bad++; $display("FAIL %s after_done: got done=%b err=%b bad=%b want 0/%b/0", nm, tx_done, tx_err, bad_cmd, err_flag);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    total++;
    if (cmd_ready !== 1'b1 || pl_ready !== 1'b0 || pkt_valid !== 1'b0 || data_in !== 8'h00 ||
        tx_done !== 1'b0 || tx_err !== 1'b0 || bad_cmd !== 1'b0) begin
      bad++; $display("FAIL reset_vals: got rdy=%b plr=%b pv=%b d=%h done=%b err=%b bad=%b want 1/0/0/00/0/0/0",
                      cmd_ready, pl_ready, pkt_valid, data_in, tx_done, tx_err, bad_cmd);
    end
    reset = 1'b0;
    tick();
    total++;
    if (cmd_ready !== 1'b1 || pkt_valid !== 1'b0) begin
      bad++; $display("FAIL reset_release: got rdy=%b pv=%b want 1/0", cmd_ready, pkt_valid);
    end
  endtask

  task automatic test_single();
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    run_pkt("single", 2'd1, 6'd3, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_busy();
    pay[0] = 8'hA5; pay[1] = 8'h5A;
    run_pkt("busy", 2'd2, 6'd2, 128'h2E, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_illegal();
    int pulses;
    pulses = 0;
    for (int k = 0; k < 2; k++) begin
      send_cmd((k == 0) ? 2'd3 : 2'd0, (k == 0) ? 6'd4 : 6'd0);
      for (int c = 0; c < 3; c++) begin
        if (bad_cmd === 1'b1) pulses++;
        total++;
        if (pkt_valid !== 1'b0 || pl_ready !== 1'b0 || cmd_ready !== 1'b1) begin
          bad++; $display("FAIL illegal_idle: cmd %0d got pv=%b plr=%b rdy=%b want 0/0/1", k, pkt_valid, pl_ready, cmd_ready);
        end
        tick();
      end
    end
    total++;
    if (pulses != 2) begin
      bad++; $display("FAIL illegal_pulses: got %0d want 2", pulses);
    end
  endtask

  task automatic test_max_len();
    for (int i = 0; i < 63; i++) pay[i] = 8'(i * 7 + 3);
    run_pkt("maxlen", 2'd2, 6'd63, '0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_error();
    for (int i = 0; i < 5; i++) pay[i] = 8'hC0 + 8'(i);
    run_pkt("err_pkt", 2'd0, 6'd5, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    pay[0] = 8'h77;
    run_pkt("err_next", 2'd1, 6'd1, 128'h4, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) pay[i] = 8'h40 + 8'(i);
    send_cmd(2'd0, 6'd10);
    fill(10, 1'b0);
    for (int c = 0; c < 6; c++) tick();
    total++;
    if (data_in !== pay[5] || pkt_valid !== 1'b1) begin
      bad++; $display("FAIL rst_mid_pre: got %h/%b want %h/1", data_in, pkt_valid, pay[5]);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (pkt_valid !== 1'b0 || cmd_ready !== 1'b1 || pl_ready !== 1'b0 || data_in !== 8'h00) begin
      bad++; $display("FAIL rst_mid_post: got pv=%b rdy=%b plr=%b d=%h want 0/1/0/00", pkt_valid, cmd_ready, pl_ready, data_in);
    end
    for (int i = 0; i < 4; i++) pay[i] = 8'h90 ^ 8'(i);
    run_pkt("after_rst", 2'd2, 6'd4, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    pl_valid = 1'b0; pl_data = '0; busy = 1'b0; err = 1'b0;
    test_reset();
    test_single();
    test_busy();
    test_illegal();
    test_max_len();
    test_error();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
